txuart_arbiter: RTL and testbench
=================================

// Module: txuart_arbiter
//
// PURPOSE
//  Shares one txuart transmitter among NCHAN message sources (memory-driven
//  message generators, debug printers) with message-granular round-robin
//  arbitration: a granted source keeps the UART until its last byte is
//  accepted, so messages never interleave. Sits between the sources and
//  txuart. Drives txuart's stb/data and returns txuart's busy to the owner.
//
// PARAMETERS
//  NCHAN      4     number of requesting sources (2..8)
//  LGTIMEOUT  10    width of stall counter; stall limit = 2**LGTIMEOUT clocks
//
// PORTS
//  i_clk      in   1        system clock
//  i_reset    in   1        asynchronous, active-high reset
//  i_stb      in   NCHAN    per-source byte request; held until accepted
//  i_data     in   8*NCHAN  per-source byte; source n on [8n+7:8n]
//  i_last     in   NCHAN    per-source flag: current byte ends the message
//  o_busy     out  NCHAN    per-source busy; byte n accepted when i_stb[n]&&!o_busy[n]
//  o_grant    out  NCHAN    one-hot current owner, all-zero when idle
//  o_abort    out  1        one-cycle pulse: owner released by stall timeout
//  o_tx_stb   out  1        to txuart i_wr
//  o_tx_data  out  8        to txuart i_data
//  i_tx_busy  in   1        from txuart o_busy
//
// BEHAVIOUR
//  - Reset (async, any time): state=IDLE, o_grant=0, o_busy=all 1s,
//    o_tx_stb=0, o_tx_data=0, o_abort=0, last_owner=NCHAN-1 (ch 0 first),
//    stall counter=2**LGTIMEOUT-1. A reset mid-message drops o_tx_stb at
//    once; an in-flight txuart byte completes on its own.
//  - States: IDLE, ACTIVE(owner g).
//  - IDLE: o_busy all 1s, o_tx_stb=0, o_tx_data=0. If any i_stb set, pick
//    the first requester at or after last_owner+1 (mod NCHAN); next cycle
//    state=ACTIVE, o_grant=1<<g, stall counter reloaded. Grant latency: 1 clk.
//  - ACTIVE (combinational pass-through, no added latency):
//    o_tx_stb=i_stb[g], o_tx_data=i_data[g], o_busy[g]=i_tx_busy,
//    o_busy[n!=g]=1. Byte accepted when i_stb[g]&&!i_tx_busy.
//  - Accept with i_last[g]=1 -> next cycle IDLE, last_owner=g. At least one
//    IDLE clock always separates two grants (also to the same source).
//  - Stall counter: reloads on every accept; decrements each ACTIVE clock
//    with !i_stb[g]; holds while i_stb[g] stays high (UART busy is not a
//    stall). Reaching 0 -> next cycle IDLE, last_owner=g, o_abort=1 one clk.
//    An accept reloads, so accept and timeout never coincide.
//  - Sources not granted see busy=1 and must hold stb/data; changing them
//    is legal, nothing is latched.
//  - o_grant always zero or one-hot; o_tx_stb never 1 in IDLE.
//
// TESTING
//  1. Reset, ch0 sends 3 bytes (last on 3rd), txuart busy 4 clk per byte
//     -> o_grant=0001 one clk after i_stb[0], 3 bytes out in order, IDLE after.
//  2. ch1 and ch3 request together from reset -> ch1 served first (whole
//     msg), then ch3; with ch1 requesting again -> order 1,3,1.
//  3. ch2 owns, drops stb after byte 1 for 2**LGTIMEOUT clocks -> o_abort
//     pulses once, grant clears, ch0 (waiting) granted next.
//  4. Non-owner ch0 toggles i_stb/i_data during ch2 message -> o_tx_data
//     only ever ch2 bytes, o_busy[0]=1 throughout.
//  5. i_reset asserted asynchronously mid-byte while o_tx_stb=1 -> o_tx_stb,
//     o_grant go 0 before next clock edge; after release ch0 has priority.
//  Formal: one-hot grant, no stb in IDLE, no byte from non-owner, cover
//     two back-to-back messages from different sources.

Source files
------------

// File: rtl/txuart_arbiter.sv
// Message-granular round-robin arbiter sharing one txuart among NCHAN sources.
// The owner keeps the UART until its last byte is accepted or it stalls too long.
module txuart_arbiter #(
    parameter int NCHAN     = 4,
    parameter int LGTIMEOUT = 10
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [NCHAN-1:0]     i_stb,
    input  logic [8*NCHAN-1:0]   i_data,
    input  logic [NCHAN-1:0]     i_last,
    output logic [NCHAN-1:0]     o_busy,
    output logic [NCHAN-1:0]     o_grant,
    output logic                 o_abort,
    output logic                 o_tx_stb,
    output logic [7:0]           o_tx_data,
    input  logic                 i_tx_busy
);

    localparam int LGN = (NCHAN > 1) ? $clog2(NCHAN) : 1;

    typedef enum logic {
        S_IDLE,
        S_ACTIVE
    } state_t;

    state_t               r_state, w_next_state;
    logic [LGN-1:0]       r_owner, w_next_owner;
    logic [LGN-1:0]       r_last_owner, w_next_last;
    logic [LGTIMEOUT-1:0] r_stall, w_next_stall;
    logic                 r_abort, w_next_abort;
    logic                 w_pick_valid;
    logic [LGN-1:0]       w_pick;
    logic                 w_owner_stb;
    logic                 w_accept;

    assign w_owner_stb = i_stb[r_owner];
    assign o_abort     = r_abort;

    // Search starts one past the previous owner and wraps, so the previous owner is tried last.
    always_comb begin : pick_blk
        int unsigned idx;
        w_pick       = '0;
        w_pick_valid = 1'b0;
        idx          = 0;
        for (int unsigned i = 1; i <= NCHAN; i++) begin
            idx = 32'(r_last_owner) + i;
            if (idx >= unsigned'(NCHAN))
                idx = idx - unsigned'(NCHAN);
            if (!w_pick_valid && i_stb[idx[LGN-1:0]]) begin
                w_pick_valid = 1'b1;
                w_pick       = idx[LGN-1:0];
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_owner = r_owner;
        w_next_last  = r_last_owner;
        w_next_stall = r_stall;
        w_next_abort = 1'b0;
        w_accept     = 1'b0;
        o_busy       = '1;
        o_grant      = '0;
        o_tx_stb     = 1'b0;
        o_tx_data    = '0;
        case (r_state)
            S_IDLE: begin
                if (w_pick_valid) begin
                    w_next_state = S_ACTIVE;
                    w_next_owner = w_pick;
                    w_next_stall = '1;
                end
            end
            S_ACTIVE: begin
                o_grant[r_owner] = 1'b1;
                o_tx_stb         = w_owner_stb;
                o_tx_data        = i_data[{r_owner, 3'b000} +: 8];
                o_busy[r_owner]  = i_tx_busy;
                w_accept         = w_owner_stb && !i_tx_busy;
                if (w_accept) begin
                    w_next_stall = '1;
                    if (i_last[r_owner]) begin
                        w_next_state = S_IDLE;
                        w_next_last  = r_owner;
                    end
                end else if (!w_owner_stb) begin
                    // Only a silent owner counts down; waiting on the UART is not a stall.
                    if (r_stall == '0) begin
                        w_next_state = S_IDLE;
                        w_next_last  = r_owner;
                        w_next_abort = 1'b1;
                    end else begin
                        w_next_stall = r_stall - LGTIMEOUT'(1);
                    end
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_owner      <= '0;
            r_last_owner <= LGN'(NCHAN - 1);
            r_stall      <= '1;
            r_abort      <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_owner      <= w_next_owner;
            r_last_owner <= w_next_last;
            r_stall      <= w_next_stall;
            r_abort      <= w_next_abort;
        end
    end

endmodule

// File: tb/tb_txuart_arbiter.sv
// Self-checking bench for txuart_arbiter: random messages and UART busy times
// compared each cycle against a message-level arbitration model.
module tb_txuart_arbiter;

    localparam int NCHAN   = 4;
    localparam int LGT     = 4;
    localparam int TIMEOUT = 1 << LGT;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [NCHAN-1:0]     stb, last, busy, grant;
    logic [8*NCHAN-1:0]   data;
    logic                 abort, tx_stb, tx_busy;
    logic [7:0]           tx_data;

    always #5 clk = ~clk;

    txuart_arbiter #(.NCHAN(NCHAN), .LGTIMEOUT(LGT)) dut (
        .i_clk(clk), .i_reset(rst), .i_stb(stb), .i_data(data), .i_last(last),
        .o_busy(busy), .o_grant(grant), .o_abort(abort), .o_tx_stb(tx_stb),
        .o_tx_data(tx_data), .i_tx_busy(tx_busy)
    );

    typedef struct {
        logic [7:0] d;
        logic       l;
    } ent_t;

    ent_t       src_q[NCHAN][$];
    logic [7:0] exp_stream[NCHAN][$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         m_owner  = -1;
    int         m_last   = NCHAN - 1;
    int         m_quiet  = 0;
    bit         m_abort  = 1'b0;
    int         tx_left  = 0;
    int         busy_len = 4;
    bit         busy_rand = 1'b0;
    bit [NCHAN-1:0] src_en = '1;
    bit         noise0 = 1'b0;
    int         grant_log[$];
    int         abort_seen = 0;
    logic [NCHAN-1:0] prev_grant = '0;

    task automatic send_msg(input int ch, input int len);
        ent_t e;
        for (int i = 0; i < len; i++) begin
            e.d = 8'($urandom);
            e.l = (i == len - 1);
            src_q[ch].push_back(e);
            exp_stream[ch].push_back(e.d);
        end
    endtask

    task automatic drive_sources();
        for (int n = 0; n < NCHAN; n++) begin
            if (src_en[n] && src_q[n].size() > 0) begin
                stb[n]         = 1'b1;
                data[8*n +: 8] = src_q[n][0].d;
                last[n]        = src_q[n][0].l;
            end else begin
                stb[n]         = 1'b0;
                data[8*n +: 8] = 8'h00;
                last[n]        = 1'b0;
            end
        end
        if (noise0 && m_owner == 2) begin
            stb[0]    = 1'($urandom);
            data[7:0] = 8'($urandom);
            last[0]   = 1'($urandom);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_last  = NCHAN - 1;
        m_quiet = 0;
        m_abort = 1'b0;
    endtask

    // One clock: compare at the falling edge, then advance model, UART and sources.
    task automatic clock_cycle();
        logic [NCHAN-1:0] e_grant, e_busy, s_stb, s_last, src_acc;
        logic             e_txstb, s_rst, m_acc, dut_acc;
        logic [7:0]       e_data, e_byte;
        @(negedge clk);
        s_stb = stb; s_last = last; s_rst = rst;
        e_grant = '0; e_busy = '1; e_txstb = 1'b0; e_data = '0; m_acc = 1'b0;
        if (m_owner >= 0) begin
            e_grant[m_owner] = 1'b1;
            e_busy[m_owner]  = tx_busy;
            e_txstb          = stb[m_owner];
            e_data           = data[8*m_owner +: 8];
            m_acc            = stb[m_owner] && !tx_busy;
        end
        n_checks += 5;
        if (grant !== e_grant) begin n_fail++; $display("FAIL grant @%0t: got %b want %b", $time, grant, e_grant); end
        if (busy !== e_busy) begin n_fail++; $display("FAIL busy @%0t: got %b want %b", $time, busy, e_busy); end
        if (tx_stb !== e_txstb) begin n_fail++; $display("FAIL tx_stb @%0t: got %b want %b", $time, tx_stb, e_txstb); end
        if (tx_data !== e_data) begin n_fail++; $display("FAIL tx_data @%0t: got %02h want %02h", $time, tx_data, e_data); end
        if (abort !== m_abort) begin n_fail++; $display("FAIL abort @%0t: got %b want %b", $time, abort, m_abort); end
        src_acc = stb & ~busy;
        dut_acc = tx_stb && !tx_busy;
        if (dut_acc === 1'b1) begin
            n_checks++;
            if (m_owner < 0 || exp_stream[m_owner].size() == 0) begin
                n_fail++;
                $display("FAIL byte_owner @%0t: byte %02h sent, model owner %0d has nothing pending", $time, tx_data, m_owner);
            end else begin
                e_byte = exp_stream[m_owner].pop_front();
                if (tx_data !== e_byte) begin
                    n_fail++;
                    $display("FAIL byte_order @%0t: ch%0d sent %02h want %02h", $time, m_owner, tx_data, e_byte);
                end
            end
        end
        if (grant != '0 && prev_grant == '0)
            for (int n = 0; n < NCHAN; n++) if (grant[n]) grant_log.push_back(n);
        prev_grant = grant;
        if (abort === 1'b1) abort_seen++;
        @(posedge clk);
        #1;
        if (s_rst) begin
            model_reset();
        end else begin
            m_abort = 1'b0;
            if (m_owner < 0) begin
                for (int k = 1; k <= NCHAN; k++) begin
                    if (s_stb[(m_last + k) % NCHAN]) begin
                        m_owner = (m_last + k) % NCHAN;
                        m_quiet = 0;
                        break;
                    end
                end
            end else if (m_acc) begin
                m_quiet = 0;
                if (s_last[m_owner]) begin
                    m_last  = m_owner;
                    m_owner = -1;
                end
            end else if (!s_stb[m_owner]) begin
                m_quiet++;
                if (m_quiet == TIMEOUT) begin
                    m_last  = m_owner;
                    m_owner = -1;
                    m_abort = 1'b1;
                end
            end
        end
        if (dut_acc === 1'b1) tx_left = busy_rand ? int'($urandom_range(0, 4)) : busy_len;
        else if (tx_left > 0) tx_left--;
        tx_busy = (tx_left > 0);
        for (int n = 0; n < NCHAN; n++)
            if (src_acc[n] === 1'b1 && src_q[n].size() > 0) src_q[n].delete(0);
        drive_sources();
    endtask

    function automatic bit all_drained();
        for (int n = 0; n < NCHAN; n++)
            if (src_q[n].size() > 0 || exp_stream[n].size() > 0) return 1'b0;
        return (m_owner < 0) && (tx_left == 0);
    endfunction

    task automatic wait_done(input int max_cycles, input string name);
        bit done = 1'b0;
        for (int i = 0; i < max_cycles && !done; i++) begin
            if (all_drained()) done = 1'b1;
            else clock_cycle();
        end
        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s_timeout: messages still pending after %0d cycles, required drained", name, max_cycles);
        end
    endtask

    task automatic check_grants(input string name, input int exp_g[$]);
        n_checks++;
        if (grant_log.size() != exp_g.size()) begin
            n_fail++;
            $display("FAIL %s_grant_count: got %0d grants %p want %p", name, grant_log.size(), grant_log, exp_g);
        end else begin
            foreach (exp_g[i]) begin
                n_checks++;
                if (grant_log[i] != exp_g[i]) begin
                    n_fail++;
                    $display("FAIL %s_grant_order[%0d]: got ch%0d want ch%0d", name, i, grant_log[i], exp_g[i]);
                end
            end
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        clock_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_checks += 5;
        if (grant !== '0) begin n_fail++; $display("FAIL reset_grant: got %b want 0", grant); end
        if (busy !== '1) begin n_fail++; $display("FAIL reset_busy: got %b want all ones", busy); end
        if (tx_stb !== 1'b0) begin n_fail++; $display("FAIL reset_tx_stb: got %b want 0", tx_stb); end
        if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %02h want 00", tx_data); end
        if (abort !== 1'b0) begin n_fail++; $display("FAIL reset_abort: got %b want 0", abort); end
        clock_cycle();
        clock_cycle();
        rst = 1'b0;
    endtask

    task automatic test_single();
        grant_log.delete();
        busy_rand = 1'b0; busy_len = 4;
        send_msg(0, 3);
        drive_sources();
        clock_cycle();
        #1;
        n_checks++;
        if (grant !== 4'b0001) begin n_fail++; $display("FAIL single_grant_latency: got %b want 0001", grant); end
        wait_done(200, "single");
        check_grants("single", '{0});
    endtask

    task automatic test_round_robin();
        grant_log.delete();
        pulse_reset();
        busy_rand = 1'b1;
        send_msg(1, int'($urandom_range(1, 4)));
        send_msg(3, int'($urandom_range(1, 4)));
        send_msg(1, int'($urandom_range(1, 4)));
        drive_sources();
        wait_done(400, "rr");
        check_grants("rr", '{1, 3, 1});
    endtask

    task automatic test_timeout();
        bit seen = 1'b0;
        grant_log.delete();
        abort_seen = 0;
        busy_rand = 1'b0; busy_len = 2;
        send_msg(2, 3);
        drive_sources();
        for (int i = 0; i < 50 && !seen; i++) begin
            clock_cycle();
            if (exp_stream[2].size() == 2) seen = 1'b1;
        end
        src_en[2] = 1'b0;
        send_msg(0, 2);
        drive_sources();
        seen = 1'b0;
        for (int i = 0; i < TIMEOUT + 40 && !seen; i++) begin
            clock_cycle();
            if (abort_seen > 0) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL timeout_abort: no abort pulse within %0d cycles", TIMEOUT + 40); end
        src_q[2].delete();
        exp_stream[2].delete();
        src_en[2] = 1'b1;
        drive_sources();
        wait_done(200, "timeout");
        n_checks++;
        if (abort_seen != 1) begin n_fail++; $display("FAIL timeout_abort_count: got %0d pulses want 1", abort_seen); end
        check_grants("timeout", '{2, 0});
    endtask

    task automatic test_nonowner();
        bit done = 1'b0;
        grant_log.delete();
        noise0 = 1'b1;
        busy_rand = 1'b1;
        send_msg(2, 5);
        drive_sources();
        for (int i = 0; i < 300 && !done; i++) begin
            clock_cycle();
            #1;
            if (grant[2] === 1'b1) begin
                n_checks++;
                if (busy[0] !== 1'b1) begin n_fail++; $display("FAIL nonowner_busy: ch0 busy got %b want 1", busy[0]); end
            end
            if (all_drained()) done = 1'b1;
        end
        n_checks++;
        if (!done) begin n_fail++; $display("FAIL nonowner_timeout: ch2 message not drained"); end
        noise0 = 1'b0;
        drive_sources();
        check_grants("nonowner", '{2});
    endtask

    task automatic test_async_reset();
        bit seen = 1'b0;
        grant_log.delete();
        busy_rand = 1'b0; busy_len = 6;
        send_msg(3, 3);
        drive_sources();
        for (int i = 0; i < 50 && !seen; i++) begin
            clock_cycle();
            if (m_owner == 3 && tx_left > 0 && src_q[3].size() > 0) seen = 1'b1;
        end
        #2;
        n_checks++;
        if (tx_stb !== 1'b1) begin n_fail++; $display("FAIL areset_pre_stb: got %b want 1", tx_stb); end
        rst = 1'b1;
        #1;
        n_checks += 3;
        if (tx_stb !== 1'b0) begin n_fail++; $display("FAIL areset_tx_stb: got %b want 0", tx_stb); end
        if (grant !== '0) begin n_fail++; $display("FAIL areset_grant: got %b want 0", grant); end
        if (busy !== '1) begin n_fail++; $display("FAIL areset_busy: got %b want all ones", busy); end
        model_reset();
        for (int n = 0; n < NCHAN; n++) begin
            src_q[n].delete();
            exp_stream[n].delete();
        end
        drive_sources();
        clock_cycle();
        clock_cycle();
        rst = 1'b0;
        grant_log.delete();
        send_msg(0, 2);
        send_msg(3, 2);
        drive_sources();
        wait_done(200, "areset");
        check_grants("areset", '{0, 3});
    endtask

    task automatic test_back_to_back();
        grant_log.delete();
        busy_rand = 1'b1;
        send_msg(1, 2);
        send_msg(2, 3);
        drive_sources();
        wait_done(200, "b2b");
        check_grants("b2b", '{1, 2});
    endtask

    task automatic test_random();
        busy_rand = 1'b1;
        for (int r = 0; r < 8; r++) begin
            for (int ch = 0; ch < NCHAN; ch++)
                if ($urandom_range(0, 1) == 1) send_msg(ch, int'($urandom_range(1, 4)));
            drive_sources();
            wait_done(600, "random");
        end
    endtask

    initial begin
        stb = '0; data = '0; last = '0; tx_busy = 1'b0;
        #1 rst = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_nonowner();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
